// File: rtl/if_prefetch.sv
// Instruction-fetch front end: byte-serial reads assembled into 32-bit words,
// queued as {pc, inst} pairs for the decode stage.
module if_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_in,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_din_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        stall_req_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [1:0]    byte_idx;
  logic          pend;
  logic [1:0]    pend_idx;
  logic [23:0]   asm_lo;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          flush_take;
  logic          full;
  logic          grant;
  logic          capture;
  logic          push;
  logic          pop;

  assign flush_take = flush_i & rdy_in;
  assign full       = (count == CW'(DEPTH));
  assign valid_o    = (count != '0);

  assign mem_req_o  = rst & rdy_in & ~flush_i & ~full;
  assign mem_addr_o = fetch_pc + {30'd0, byte_idx};

  assign grant   = mem_req_o & mem_gnt_i;
  assign capture = pend & ~flush_take;
  assign push    = capture & (pend_idx == 2'd3);
  assign pop     = ready_i & valid_o & rdy_in & ~flush_take;

  assign pc_o        = valid_o ? pc_mem[rd_ptr]   : '0;
  assign inst_o      = valid_o ? inst_mem[rd_ptr] : '0;
  assign stall_req_o = ~valid_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      byte_idx <= '0;
      pend     <= 1'b0;
      pend_idx <= '0;
    end else begin
      pend <= grant;
      if (grant)
        pend_idx <= byte_idx;
      // fetch_pc steps at the last grant so the next word's
      // byte 0 can issue back-to-back
      if (flush_take) begin
        fetch_pc <= flush_pc_i;
        byte_idx <= '0;
      end else if (grant) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3)
          fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_lo <= '0;
    end else if (flush_take) begin
      asm_lo <= '0;
    end else if (capture) begin
      unique case (1'b1)
        (pend_idx == 2'd0): asm_lo[7:0]   <= mem_din_i;
        (pend_idx == 2'd1): asm_lo[15:8]  <= mem_din_i;
        (pend_idx == 2'd2): asm_lo[23:16] <= mem_din_i;
        (pend_idx == 2'd3): ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_take) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // fetch_pc already points past the word whose last byte lands now
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc - 32'd4;
      inst_mem[wr_ptr] <= {mem_din_i, asm_lo};
    end
  end

  a_count_range: assert property (
    @(posedge clk) disable iff (!rst)
    count <= CW'(DEPTH));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(push && full && !pop));

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: byte memory model, expected-word scoreboard
// drained by a negedge monitor, plus directed latency/freeze checks.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy_in;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_din_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        stall_req_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   gnt_toggle = 1'b0;

  if_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy_in     (rdy_in),
    .flush_i    (flush_i),
    .flush_pc_i (flush_pc_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_gnt_i  (mem_gnt_i),
    .mem_din_i  (mem_din_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .pc_o       (pc_o),
    .inst_o     (inst_o),
    .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  // Bytes 0..3 hold 13 00 00 00; elsewhere byte = addr[7:0] + 0x40
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] boot;
    int sh;
    boot = 32'h0000_0013;
    sh = 8 * int'(a[1:0]);
    if (a < 32'd4)
      return boot[sh +: 8];
    return a[7:0] + 8'h40;
  endfunction

  always @(posedge clk)
    mem_din_i <= (mem_req_o && mem_gnt_i) ? mem_byte(mem_addr_o) : 8'h00;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (gnt_toggle)
      mem_gnt_i = ~mem_gnt_i;
  endtask

  task automatic expect_word(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    e.pc = pc;
    e.inst = inst;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      n++;
      @(negedge clk);
      if (valid_o)
        done = 1'b1;
      else
        step();
    end
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      step();
      k++;
    end
    ready_i = 1'b0;
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"},   mem_req_o,   1'b0);
    chk({tag, "_addr"},  mem_addr_o,  32'h0);
    chk({tag, "_valid"}, valid_o,     1'b0);
    chk({tag, "_pc"},    pc_o,        32'h0);
    chk({tag, "_inst"},  inst_o,      32'h0);
    chk({tag, "_stall"}, stall_req_o, 1'b1);
  endtask

  task automatic monitor();
    exp_t        e;
    bit          prev_hold;
    logic [31:0] prev_addr;
    prev_hold = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_hold = 1'b0;
        continue;
      end
      if (valid_o && ready_i && rdy_in && !flush_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc %h want none", pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", pc_o, e.pc);
          chk("pop_inst", inst_o, e.inst);
        end
      end
      if (prev_hold && mem_req_o)
        chk("addr_hold", mem_addr_o, prev_addr);
      prev_hold = mem_req_o && !mem_gnt_i;
      prev_addr = mem_addr_o;
    end
  endtask

  initial begin
    int n;
    int k;
    rst = 1'b0;
    rdy_in = 1'b1;
    flush_i = 1'b0;
    flush_pc_i = '0;
    mem_gnt_i = 1'b1;
    ready_i = 1'b0;
    fork
      monitor();
    join_none

    repeat (2) step();
    @(negedge clk);
    check_reset("reset");

    // boot word, FIFO fills while if_id holds off
    step();
    rst = 1'b1;
    wait_valid(n);
    chk("boot_latency", n, 6);
    chk("boot_pc", pc_o, 32'h0);
    chk("boot_inst", inst_o, 32'h0000_0013);
    k = 0;
    while (mem_req_o && k < 40) begin
      step();
      k++;
    end
    repeat (3) step();
    @(negedge clk);
    chk("full_req", mem_req_o, 1'b0);
    chk("full_valid", valid_o, 1'b1);
    chk("full_head_pc", pc_o, 32'h0);
    chk("full_stall", stall_req_o, 1'b0);

    // drain one per cycle
    step();
    expect_word(32'h0, 32'h0000_0013);
    expect_word(32'h4, 32'h4746_4544);
    expect_word(32'h8, 32'h4B4A_4948);
    expect_word(32'hC, 32'h4F4E_4D4C);
    ready_i = 1'b1;
    step();
    @(negedge clk);
    chk("resume_req", mem_req_o, 1'b1);
    repeat (3) step();
    chk("one_pop_per_cycle", exp_q.size(), 0);
    ready_i = 1'b0;

    // grant only every other cycle
    expect_word(32'h10, 32'h5352_5150);
    expect_word(32'h14, 32'h5756_5554);
    expect_word(32'h18, 32'h5B5A_5958);
    expect_word(32'h1C, 32'h5F5E_5D5C);
    expect_word(32'h20, 32'h6362_6160);
    expect_word(32'h24, 32'h6766_6564);
    expect_word(32'h28, 32'h6B6A_6968);
    expect_word(32'h2C, 32'h6F6E_6D6C);
    gnt_toggle = 1'b1;
    ready_i = 1'b1;
    drain(300);
    gnt_toggle = 1'b0;
    mem_gnt_i = 1'b1;

    // redirect to 0x8, then again to 0x100 with byte 2 in flight
    step();
    flush_i = 1'b1;
    flush_pc_i = 32'h8;
    step();
    flush_i = 1'b0;
    #1;
    chk("flush_valid", valid_o, 1'b0);
    chk("flush_addr", mem_addr_o, 32'h8);
    repeat (3) step();
    chk("inflight_addr", mem_addr_o, 32'hB);
    flush_i = 1'b1;
    flush_pc_i = 32'h100;
    step();
    flush_i = 1'b0;
    wait_valid(n);
    chk("flush_latency", n, 6);
    chk("flush_pc", pc_o, 32'h100);
    chk("flush_inst", inst_o, 32'h4342_4140);

    // freeze mid-word with byte 1 of 0x108 in flight
    k = 0;
    while (!(mem_req_o && mem_addr_o == 32'h109) && k < 20) begin
      step();
      k++;
    end
    chk("find_109", mem_addr_o, 32'h109);
    step();
    rdy_in = 1'b0;
    ready_i = 1'b1;
    expect_word(32'h100, 32'h4342_4140);
    expect_word(32'h104, 32'h4746_4544);
    expect_word(32'h108, 32'h4B4A_4948);
    expect_word(32'h10C, 32'h4F4E_4D4C);
    repeat (3) begin
      @(negedge clk);
      chk("freeze_req", mem_req_o, 1'b0);
      chk("freeze_head", pc_o, 32'h100);
      step();
    end
    rdy_in = 1'b1;
    @(negedge clk);
    chk("unfreeze_req", mem_req_o, 1'b1);
    chk("unfreeze_addr", mem_addr_o, 32'h10A);
    drain(100);

    // reset mid-fetch
    step();
    rst = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) step();
    rst = 1'b1;
    wait_valid(n);
    chk("reboot_latency", n, 6);
    chk("reboot_pc", pc_o, 32'h0);
    chk("reboot_inst", inst_o, 32'h0000_0013);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
